// File: rtl/output_shifter_pkg.sv
// Shared state encoding and defaults for the output-device shift-register driver.
// Optional idle refresh: define OUTPUT_SHIFTER_REFRESH_EN.
package output_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int DEF_WIDTH          = 32;
    localparam int DEF_CLK_DIV        = 2;
    localparam int DEF_REFRESH_CYCLES = 1000000;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_clk_div.sv
// Prescaler for the serial clock: one-clock tick every CLK_DIV enabled clocks,
// restarted at each frame start.
module shift_clk_div
    import output_shifter_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int DW = cnt_w(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/output_device_shifter.sv
// Serialises a device value onto a 74HC595-style chain on change or after reset.
// Optional forced resend after a long idle period: OUTPUT_SHIFTER_REFRESH_EN.
module output_device_shifter
    import output_shifter_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int CLK_DIV        = DEF_CLK_DIV,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    output logic             sclk,
    output logic             sdata,
    output logic             latch,
    output logic             busy
);

    localparam int BW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bit_cnt;
    logic             pending;
    logic             start;
    logic             tick;
    logic             div_en;
    logic             refresh_hit;

    assign shifted = shift_reg << 1;
    assign start   = (state == IDLE) && (pending || (value != shadow));
    assign div_en  = (state != IDLE);

    shift_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .en    (div_en),
        .tick  (tick)
    );

`ifdef OUTPUT_SHIFTER_REFRESH_EN
    localparam int RW = cnt_w(REFRESH_CYCLES);

    logic [RW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (start) begin
            idle_cnt <= '0;
        end else if (state == IDLE && !refresh_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign refresh_hit = (state == IDLE) &&
                         (idle_cnt == RW'(REFRESH_CYCLES - 1));
`else
    // Without the idle timer the refresh period has no effect.
    assign refresh_hit = (REFRESH_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            pending   <= 1'b1;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            latch     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shadow    <= value;
                        shift_reg <= value;
                        pending   <= 1'b0;
                        bit_cnt   <= BW'(WIDTH - 1);
                        sclk      <= 1'b0;
                        sdata     <= value[WIDTH-1];
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end else if (refresh_hit) begin
                        pending <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else if (bit_cnt == '0) begin
                            sclk  <= 1'b0;
                            latch <= 1'b1;
                            state <= LATCH;
                        end else begin
                            // Data only moves on the falling edge of sclk.
                            sclk      <= 1'b0;
                            shift_reg <= shifted;
                            sdata     <= shifted[WIDTH-1];
                            bit_cnt   <= bit_cnt - 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        latch <= 1'b0;
                        sdata <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_output_device_shifter.sv
// Scoreboard bench: stimulus queues expected frames, monitors rebuild them from sclk/sdata.
module tb_output_device_shifter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic [31:0] value;
    logic [7:0]  value2;
    logic        sclk, sdata, latch, busy;
    logic        sclk2, sdata2, latch2, busy2;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  exp2_q[$];
    int          frames_seen = 0;
    int          nbits = 0;

    always #5 clk = ~clk;

    output_device_shifter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .sclk  (sclk),
        .sdata (sdata),
        .latch (latch),
        .busy  (busy)
    );

    output_device_shifter #(
        .WIDTH   (8),
        .CLK_DIV (1)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .value (value2),
        .sclk  (sclk2),
        .sdata (sdata2),
        .latch (latch2),
        .busy  (busy2)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit, CLK_DIV=2 instance
    logic [31:0] word;
    int          busy_len, lat_len;
    logic        p_sclk, p_latch, p_busy;

    always @(negedge clk) begin
        if (!rst_n) begin
            nbits = 0; word = '0; busy_len = 0; lat_len = 0;
            p_sclk = 0; p_latch = 0; p_busy = 0;
        end else begin
            if (sclk && !p_sclk) begin
                word = {word[30:0], sdata};
                nbits++;
            end
            if (latch && !p_latch) begin
                frames_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame: got %h expected none", word);
                end else begin
                    check("frame_data", word, exp_q.pop_front());
                    check("frame_bits", nbits, 32);
                end
            end
            if (latch) lat_len++;
            if (!latch && p_latch) begin
                check("latch_len", lat_len, 2);
                lat_len = 0;
            end
            if (busy) busy_len++;
            if (!busy && p_busy) begin
                check("busy_len", busy_len, 130);
                busy_len = 0; nbits = 0; word = '0;
            end
            p_sclk = sclk; p_latch = latch; p_busy = busy;
        end
    end

    // Monitor for the 8-bit, CLK_DIV=1 instance
    logic [7:0] word2;
    int         nbits2, busy2_len, lat2_len;
    logic       q_sclk, q_latch, q_busy;

    always @(negedge clk) begin
        if (!rst2_n) begin
            nbits2 = 0; word2 = '0; busy2_len = 0; lat2_len = 0;
            q_sclk = 0; q_latch = 0; q_busy = 0;
        end else begin
            if (sclk2 && !q_sclk) begin
                word2 = {word2[6:0], sdata2};
                nbits2++;
            end
            if (latch2 && !q_latch) begin
                if (exp2_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_frame8: got %h expected none", word2);
                end else begin
                    check("frame8_data", word2, exp2_q.pop_front());
                    check("frame8_bits", nbits2, 8);
                end
            end
            if (latch2) lat2_len++;
            if (!latch2 && q_latch) begin
                check("latch8_len", lat2_len, 1);
                lat2_len = 0;
            end
            if (busy2) busy2_len++;
            if (!busy2 && q_busy) begin
                check("busy8_len", busy2_len, 17);
                busy2_len = 0; nbits2 = 0; word2 = '0;
            end
            q_sclk = sclk2; q_latch = latch2; q_busy = busy2;
        end
    end

    task automatic wait_done(input bit second);
        int n;
        n = 0;
        while (!(second ? busy2 : busy) && n < 4) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while ((second ? busy2 : busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (second ? busy2 : busy) begin
            miscompares++;
            $display("FAIL frame_timeout: busy still 1 expected 0");
        end
    endtask

    int f0;

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        value  = '0;
        value2 = '0;
        #1;
        check("reset_outputs", {sclk, sdata, latch, busy}, 4'b0000);
        repeat (3) @(negedge clk);

        // Frame forced by reset with value zero
        exp_q.push_back(32'h0000_0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("busy_after_reset", busy, 1'b1);
        wait_done(1'b0);
        repeat (5) @(negedge clk);

        // Change while idle, then coalesced changes mid-frame
        check("idle_before_change", busy, 1'b0);
        value = 32'hE5F8_4AB1;
        exp_q.push_back(32'hE5F8_4AB1);
        @(negedge clk);
        check("busy_rise", busy, 1'b1);
        repeat (20) @(negedge clk);
        value = 32'h5C8C_6A01;
        repeat (30) @(negedge clk);
        value = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        wait_done(1'b0);
        @(negedge clk);
        check("idle_gap", busy, 1'b1);
        wait_done(1'b0);
        repeat (5) @(negedge clk);

        // Reset at bit 10 of a frame
        f0 = frames_seen;
        value = 32'hCAFE_F00D;
        exp_q.push_back(32'hCAFE_F00D);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nbits >= 10) break;
        end
        check("reached_bit10", (nbits >= 10), 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_midframe", {sclk, sdata, latch, busy}, 4'b0000);
        exp_q.delete();
        repeat (3) @(negedge clk);
        exp_q.push_back(32'hCAFE_F00D);
        rst_n = 1'b1;
        wait_done(1'b0);
        check("one_frame_after_abort", frames_seen, f0 + 1);

        // Constant value: no further frames
        f0 = frames_seen;
        repeat (10000) @(negedge clk);
        check("idle_no_frame", frames_seen, f0);
        check("idle_busy", busy, 1'b0);

        // Narrow instance, sclk toggling every clock
        value2 = 8'hA5;
        exp2_q.push_back(8'hA5);
        @(negedge clk);
        rst2_n = 1'b1;
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        value2 = 8'h3C;
        exp2_q.push_back(8'h3C);
        wait_done(1'b1);
        repeat (3) @(negedge clk);

        check("queues_drained", exp_q.size() + exp2_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
